pc_fetch_unit: RTL and testbench

- Program-counter register and instruction-fetch sequencer. It sits directly upstream of the next-PC logic.
- Holds the current PC, requests the word at that PC from instruction memory over a req/gnt/rvalid handshake, and buffers the returned instruction.
- Presents {pc_out, instr} to decode and next-PC logic until consumed, then loads new_pc.
- PC is a word index: sequential successor is pc+1, and imem_addr = pc with no byte shift.

---
 rtl/pc_fetch_unit.sv | 154 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register and instruction-fetch sequencer.
//
// Holds the current PC (a word index), fetches the word at that PC over a
// req/gnt/rvalid handshake, buffers the returned instruction and presents
// {pc_out, instr} to decode / next-PC logic until it is committed. On commit
// the PC is replaced verbatim by new_pc and the next fetch begins.
//
// Handshake semantics:
//   - imem_req is held high with a stable imem_addr until imem_gnt is seen
//     high on a rising edge; a request is transferred on any edge where
//     imem_req && imem_gnt. At most one request is outstanding.
//   - imem_rvalid is only honoured while a granted request is outstanding
//     (S_WAIT); elsewhere it is ignored.
//   - instr_valid stays high with stable pc_out/instr until a rising edge
//     sees instr_ready high; that edge is the commit and samples new_pc.
//
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch_cnt and stall_cnt
// performance counters as extra output ports.

module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // instruction memory side
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // decode / next-PC side
  output logic [31:0] pc_out,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [31:0] new_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
`endif
  // current FSM state, for observation only
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        req_q;

  // Named handshake events, each qualified by the state in which it counts
  logic        grant_ev;
  logic        resp_ev;
  logic        commit_ev;

  assign grant_ev  = (state_q == S_REQ)  && imem_gnt;
  assign resp_ev   = (state_q == S_WAIT) && imem_rvalid;
  assign commit_ev = (state_q == S_HOLD) && instr_ready;

  // Next-state and next-datapath logic; everything holds unless an event fires
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    case (state_q)
      S_RESET: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (grant_ev) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (resp_ev) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (commit_ev) begin
          pc_d    = new_pc;
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  // State and datapath registers; reset wins over every handshake input
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      // request flop tracks the state being entered so it is high exactly in S_REQ
      req_q   <= (state_d == S_REQ);
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign dbg_state   = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        stall_ev;

  assign stall_ev = ((state_q == S_REQ)  && !imem_gnt) ||
                    ((state_q == S_WAIT) && !imem_rvalid);

  // Free-running performance counters; both wrap naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      if (commit_ev) begin
        fetch_cnt_q <= fetch_cnt_q + 32'h1;
      end
      if (stall_ev) begin
        stall_cnt_q <= stall_cnt_q + 32'h1;
      end
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit. Inputs are driven and outputs sampled on the
// falling clock edge. An address queue holds the PCs the DUT must request in
// order and an instruction queue holds the words it must present at commit.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0010;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] new_pc;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc_out      (pc_out),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .new_pc      (new_pc),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_xfer   = 0;

  // cycle counter and count of request transfers seen on the bus
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_req && imem_gnt) n_xfer <= n_xfer + 1;
  end

  // instruction memory contents, a fixed function of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h2008_000A;
    return {~a[15:0] ^ a[31:16], a[15:0]};
  endfunction

  // ---------------------------------------------------------------- driver
  // One complete fetch: wait for the request, withhold gnt for gw cycles,
  // delay rvalid by rw cycles, hold off commit for hw cycles (optionally with
  // a spurious rvalid), then commit with new_pc = npc. Called on a negedge.
  task automatic do_fetch(input int gw, input int rw, input int hw,
                          input logic [31:0] npc, input bit spur,
                          output int commit_cyc);
    logic [31:0] a, e_addr, e_instr;
    bit got;
    got = 0;
    commit_cyc = 0;
    for (int k = 0; k < 30; k++) begin
      if (imem_req === 1'b1) begin got = 1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL req_timeout: imem_req got 0 required 1");
      return;
    end
    a = imem_addr;
    n_checks++;
    if (exp_addr_q.size() == 0) begin
      n_fail++;
      e_addr = a;
      $display("FAIL addr_order: fetch of %h with no expected address", a);
    end else begin
      e_addr = exp_addr_q.pop_front();
      if (a !== e_addr) begin
        n_fail++;
        $display("FAIL addr_order: imem_addr got %h required %h", a, e_addr);
      end
    end
    exp_q.push_back(mem_word(e_addr));

    for (int i = 0; i < gw; i++) begin
      imem_gnt = 1'b0;
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== a) begin
        n_fail++;
        $display("FAIL req_hold: req/addr got %b/%h required 1/%h", imem_req, imem_addr, a);
      end
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL req_drop: imem_req got %b required 0", imem_req);
    end

    for (int i = 0; i < rw; i++) begin
      @(negedge clk);
      n_checks++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_idle: valid/req got %b/%b required 0/0", instr_valid, imem_req);
      end
    end
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(a);
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    n_checks++;
    if (instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL valid_rise: instr_valid got %b required 1", instr_valid);
    end

    for (int i = 0; i < hw; i++) begin
      instr_ready = 1'b0;
      new_pc      = $urandom;
      if (spur) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      imem_rvalid = 1'b0;
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== exp_q[0] || pc_out !== e_addr) begin
        n_fail++;
        $display("FAIL hold_stable: valid/instr/pc got %b/%h/%h required 1/%h/%h",
                 instr_valid, instr, pc_out, exp_q[0], e_addr);
      end
    end

    // commit
    new_pc      = npc;
    instr_ready = 1'b1;
    e_instr     = exp_q.pop_front();
    n_checks++;
    if (instr !== e_instr || pc_out !== e_addr) begin
      n_fail++;
      $display("FAIL commit: instr/pc_out got %h/%h required %h/%h", instr, pc_out, e_instr, e_addr);
    end
    commit_cyc = cyc;
    exp_addr_q.push_back(npc);
    @(negedge clk);
    instr_ready = 1'b0;
    new_pc      = $urandom;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== npc) begin
      n_fail++;
      $display("FAIL next_req: valid/req/addr got %b/%b/%h required 0/1/%h",
               instr_valid, imem_req, imem_addr, npc);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    exp_addr_q.push_back(RST_PC);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; instr_ready = 0; new_pc = 0;
    apply_reset();
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 || pc_out !== RST_PC ||
        instr !== 32'h0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid/req/pc/instr/state got %b/%b/%h/%h/%0d required 0/0/%h/0/0",
               instr_valid, imem_req, pc_out, instr, dbg_state, RST_PC);
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (fetch_cnt !== 32'h0 || stall_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_cnt: fetch/stall got %h/%h required 0/0", fetch_cnt, stall_cnt);
    end
`endif
  endtask

  task automatic test_first_fetch();
    int c;
    // first S_REQ cycle is the negedge right after reset release
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL first_req: req/addr got %b/%h required 1/00000010", imem_req, imem_addr);
    end
    do_fetch(0, 0, 0, 32'h11, 1'b0, c);
  endtask

  task automatic test_stream();
    int c, prev;
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a;
      a = exp_addr_q[0];
      do_fetch(0, 0, 0, a + 32'h1, 1'b0, c);
      if (i > 0) begin
        n_checks++;
        if (c - prev != 3) begin
          n_fail++;
          $display("FAIL stream_rate: commit spacing got %0d required 3", c - prev);
        end
      end
      prev = c;
    end
  endtask

  task automatic test_gnt_stall();
    int c, x0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] s0, f0;
    s0 = stall_cnt;
    f0 = fetch_cnt;
`endif
    x0 = n_xfer;
    do_fetch(4, 0, 0, 32'h15, 1'b0, c);
    n_checks++;
    if (n_xfer - x0 != 1) begin
      n_fail++;
      $display("FAIL gnt_xfers: transfers got %0d required 1", n_xfer - x0);
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (stall_cnt - s0 !== 32'd4 || fetch_cnt - f0 !== 32'd1) begin
      n_fail++;
      $display("FAIL perf_cnt: stall/fetch delta got %0d/%0d required 4/1", stall_cnt - s0, fetch_cnt - f0);
    end
`endif
  endtask

  task automatic test_hold_spurious();
    int c;
    do_fetch(0, 0, 5, 32'h400, 1'b1, c);
    do_fetch(0, 2, 0, 32'hFFFF_FFFF, 1'b0, c);
  endtask

  task automatic test_wrap();
    int c;
    do_fetch(1, 0, 1, 32'h0, 1'b0, c);
    do_fetch(0, 0, 0, 32'h20, 1'b0, c);
  endtask

  task automatic test_reset_in_wait();
    int c;
    bit got;
    got = 0;
    for (int k = 0; k < 30; k++) begin
      if (imem_req === 1'b1) begin got = 1; break; end
      @(negedge clk);
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (!got || instr_valid !== 1'b0 || imem_req !== 1'b0 || pc_out !== RST_PC || instr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_in_wait: valid/req/pc/instr got %b/%b/%h/%h required 0/0/%h/0",
               instr_valid, imem_req, pc_out, instr, RST_PC);
    end
    exp_q.delete();
    exp_addr_q.delete();
    exp_addr_q.push_back(RST_PC);
    do_fetch(0, 0, 0, 32'h30, 1'b0, c);
  endtask

  task automatic test_random();
    int c;
    for (int i = 0; i < 6; i++) begin
      do_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom, 1'($urandom_range(0, 1)), c);
    end
    n_checks++;
    if (exp_q.size() != 0 || exp_addr_q.size() != 1) begin
      n_fail++;
      $display("FAIL queue_drain: exp_q/exp_addr_q sizes got %0d/%0d required 0/1",
               exp_q.size(), exp_addr_q.size());
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_first_fetch();
    test_stream();
    test_gnt_stall();
    test_hold_spurious();
    test_wrap();
    test_reset_in_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
